// File: rtl/ar_cycle_pkg.sv
// Shared types and constants for the AR / memory-cycle block.
package ar_cycle_pkg;

    localparam int unsigned AW         = 24;
    localparam int unsigned WSW        = 4;
    localparam int unsigned BANK_W     = 8;
    localparam int unsigned OFS_W      = 16;
    localparam int unsigned ROM_WS_DEF = 2;
    localparam int unsigned RAM_WS_DEF = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    // Registered memory-side control outputs, all active-low except done
    typedef struct packed {
        logic nromcs;
        logic nramcs;
        logic nmemr;
        logic nmemw;
        logic nwaitm;
        logic done;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{nromcs: 1'b1, nramcs: 1'b1, nmemr: 1'b1,
                                  nmemw: 1'b1, nwaitm: 1'b1, done: 1'b0};

endpackage

// File: rtl/ar_cycle_if.sv
// Bus bundle between the control unit/MBU side and the AR cycle engine.
interface ar_cycle_if;
    import ar_cycle_pkg::*;

    logic              nwrite_ar_mbx;
    logic [BANK_W-1:0] aext;
    logic [OFS_W-1:0]  ibus;
    logic              incar;
    logic              nmem;
    logic              rnw;
    logic [AW-1:0]     ab;
    logic              nromcs;
    logic              nramcs;
    logic              nmemr;
    logic              nmemw;
    logic              nwaitm;
    logic              done;

    modport master (
        output nwrite_ar_mbx, aext, ibus, incar, nmem, rnw,
        input  ab, nromcs, nramcs, nmemr, nmemw, nwaitm, done
    );

    modport slave (
        input  nwrite_ar_mbx, aext, ibus, incar, nmem, rnw,
        output ab, nromcs, nramcs, nmemr, nmemw, nwaitm, done
    );

endinterface

// File: rtl/ar_ws_counter.sv
// Loadable wait-state down-counter; zero is registered alongside the count.
module ar_ws_counter
    import ar_cycle_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           load,
    input  logic [WSW-1:0] load_val,
    input  logic           dec,
    output logic           zero
);

    logic [WSW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= '0;
            zero <= 1'b1;
        end else if (load) begin
            cnt  <= load_val;
            zero <= (load_val == '0);
        end else if (dec && !zero) begin
            cnt  <= cnt - WSW'(1);
            zero <= (cnt == WSW'(1));
        end
    end

endmodule

// File: rtl/ar_cycle.sv
// Address register plus memory-cycle FSM with registered strobes.
// Wait states are inserted only when AR_CYCLE_WAITSTATE_EN is defined.
module ar_cycle
    import ar_cycle_pkg::*;
#(
    parameter int unsigned ROM_WS = ROM_WS_DEF,
    parameter int unsigned RAM_WS = RAM_WS_DEF
) (
    input  logic       clk,
    input  logic       reset,
    ar_cycle_if.slave  bus
);

    state_t        state, state_nx;
    ctl_t          ctl_q, ctl_nx;
    logic [AW-1:0] ab_q;
    logic          armed;
    logic          accept;
    logic          rom_q, rnw_q;
    logic          rom_nx, rd_nx;
    logic          ws_zero;

`ifdef AR_CYCLE_WAITSTATE_EN
    logic           ws_load;
    logic [WSW-1:0] ws_val;

    assign ws_load = (state == SETUP);
    assign ws_val  = rom_q ? WSW'(ROM_WS) : WSW'(RAM_WS);

    ar_ws_counter u_ws_counter (
        .clk      (clk),
        .reset    (reset),
        .load     (ws_load),
        .load_val (ws_val),
        .dec      (state == STROBE),
        .zero     (ws_zero)
    );
`else
    assign ws_zero = 1'b1;
`endif

    // State and registered control outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ctl_q <= CTL_IDLE;
        end else begin
            state <= state_nx;
            ctl_q <= ctl_nx;
        end
    end

    // Next state; outputs are decoded from the state being entered
    always_comb begin
        state_nx = state;
        ctl_nx   = CTL_IDLE;
        accept   = 1'b0;
        rom_nx   = rom_q;
        rd_nx    = rnw_q;

        case (state)
            IDLE: begin
                if (!bus.nmem && armed) begin
                    accept   = 1'b1;
                    state_nx = SETUP;
                end
            end
            SETUP:   state_nx = STROBE;
            STROBE:  if (ws_zero) state_nx = HOLD;
            HOLD:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (accept) begin
            rom_nx = ab_q[AW-1];
            rd_nx  = bus.rnw;
        end

        case (state_nx)
            SETUP: begin
                ctl_nx.nromcs = !rom_nx;
                ctl_nx.nramcs = rom_nx;
                ctl_nx.nwaitm = 1'b0;
            end
            STROBE: begin
                ctl_nx.nromcs = !rom_nx;
                ctl_nx.nramcs = rom_nx;
                ctl_nx.nmemr  = !rd_nx;
                ctl_nx.nmemw  = rd_nx;
                ctl_nx.nwaitm = 1'b0;
            end
            HOLD: begin
                ctl_nx.nromcs = !rom_nx;
                ctl_nx.nramcs = rom_nx;
                ctl_nx.done   = 1'b1;
            end
            default: ;
        endcase
    end

    // Address register, cycle attributes and the nmem re-arm latch
    always_ff @(posedge clk) begin
        if (reset) begin
            ab_q  <= '0;
            armed <= 1'b0;
            rom_q <= 1'b0;
            rnw_q <= 1'b0;
        end else begin
            if (accept) begin
                rom_q <= ab_q[AW-1];
                rnw_q <= bus.rnw;
                armed <= 1'b0;
            end else if (bus.nmem && (state == IDLE || state == HOLD)) begin
                armed <= 1'b1;
            end

            if (state == IDLE) begin
                if (!bus.nwrite_ar_mbx)
                    ab_q <= {bus.aext, bus.ibus};
                else if (bus.incar)
                    ab_q[OFS_W-1:0] <= ab_q[OFS_W-1:0] + OFS_W'(1);
            end
        end
    end

    assign bus.ab     = ab_q;
    assign bus.nromcs = ctl_q.nromcs;
    assign bus.nramcs = ctl_q.nramcs;
    assign bus.nmemr  = ctl_q.nmemr;
    assign bus.nmemw  = ctl_q.nmemw;
    assign bus.nwaitm = ctl_q.nwaitm;
    assign bus.done   = ctl_q.done;

endmodule

// File: tb/tb_ar_cycle.sv
// Self-checking bench for ar_cycle against a cycle-timeline reference model.
module tb_ar_cycle;

    localparam int unsigned ROM_WS_P = 2;
    localparam int unsigned RAM_WS_P = 0;
`ifdef AR_CYCLE_WAITSTATE_EN
    localparam int ROM_WS_E = ROM_WS_P;
    localparam int RAM_WS_E = RAM_WS_P;
`else
    localparam int ROM_WS_E = 0;
    localparam int RAM_WS_E = 0;
`endif
    localparam logic [29:0] RESET_VEC = {24'h000000, 5'b11111, 1'b0};

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    ar_cycle_if bus ();

    ar_cycle #(.ROM_WS(ROM_WS_P), .RAM_WS(RAM_WS_P)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a memory cycle is a timeline of 3+WS positions
    logic [23:0] m_ab;
    logic        m_busy, m_armed, m_rom, m_rd;
    int          m_k, m_ws;

    task automatic tick();
        logic region;
        logic idle, acc;
        @(posedge clk);
        if (rst) begin
            m_ab = '0; m_busy = 1'b0; m_armed = 1'b0; m_k = 0;
        end else begin
            idle   = !m_busy;
            region = m_ab[23];
            acc    = idle && !bus.nmem && m_armed;
            if (acc)
                m_armed = 1'b0;
            else if (bus.nmem && (idle || m_k == m_ws + 3))
                m_armed = 1'b1;
            if (idle) begin
                if (!bus.nwrite_ar_mbx) m_ab = {bus.aext, bus.ibus};
                else if (bus.incar)     m_ab[15:0] = m_ab[15:0] + 16'd1;
            end
            if (acc) begin
                m_rom = region; m_rd = bus.rnw;
                m_ws = region ? ROM_WS_E : RAM_WS_E;
                m_busy = 1'b1; m_k = 1;
            end else if (m_busy) begin
                if (m_k == m_ws + 3) m_busy = 1'b0;
                else m_k++;
            end
        end
        #1;
    endtask

    function automatic logic [29:0] exp_vec();
        logic cs, strb, nw, dn;
        int last;
        cs = 1'b1; strb = 1'b1; nw = 1'b1; dn = 1'b0;
        if (m_busy) begin
            last = m_ws + 3;
            cs   = 1'b0;
            strb = !(m_k >= 2 && m_k <= last - 1);
            nw   = !(m_k <= last - 1);
            dn   = (m_k == last);
        end
        return {m_ab, (m_rom ? cs : 1'b1), (m_rom ? 1'b1 : cs),
                (m_rd ? strb : 1'b1), (m_rd ? 1'b1 : strb), nw, dn};
    endfunction

    function automatic logic [29:0] dut_vec();
        return {bus.ab, bus.nromcs, bus.nramcs, bus.nmemr, bus.nmemw, bus.nwaitm, bus.done};
    endfunction

    task automatic idle_inputs();
        bus.nwrite_ar_mbx = 1'b1; bus.incar = 1'b0; bus.nmem = 1'b1; bus.rnw = 1'b1;
        bus.aext = 8'h00; bus.ibus = 16'h0000;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle_inputs(); bus.nmem = 1'b0;
        tick(); tick();
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++; $display("FAIL reset_values got %h exp %h", dut_vec(), RESET_VEC);
        end
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        checks++;
        if (dut_vec() !== exp_vec() || bus.nwaitm !== 1'b1) begin
            errors++; $display("FAIL reset_disarmed got %h exp %h", dut_vec(), exp_vec());
        end
        bus.nmem = 1'b1; tick();
    endtask

    task automatic test_load_inc();
        bus.nwrite_ar_mbx = 1'b0; bus.aext = 8'h80; bus.ibus = 16'h1234; tick();
        bus.nwrite_ar_mbx = 1'b1; bus.incar = 1'b1;
        tick(); tick(); tick();
        bus.incar = 1'b0;
        checks++;
        if (bus.ab !== 24'h801237 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL load_inc got %h exp %h", bus.ab, 24'h801237);
        end
    endtask

    task automatic test_wrap();
        bus.nwrite_ar_mbx = 1'b0; bus.aext = 8'h00; bus.ibus = 16'hFFFF; tick();
        bus.nwrite_ar_mbx = 1'b1; bus.incar = 1'b1; tick();
        bus.incar = 1'b0;
        checks++;
        if (bus.ab !== 24'h000000) begin
            errors++; $display("FAIL offset_wrap got %h exp %h", bus.ab, 24'h000000);
        end
        bus.nwrite_ar_mbx = 1'b0; bus.incar = 1'b1; bus.aext = 8'h5A; bus.ibus = 16'h0F0F; tick();
        bus.nwrite_ar_mbx = 1'b1; bus.incar = 1'b0;
        checks++;
        if (bus.ab !== 24'h5A0F0F) begin
            errors++; $display("FAIL load_priority got %h exp %h", bus.ab, 24'h5A0F0F);
        end
    endtask

    task automatic test_rom_read();
        int cs_n, rd_n, ram_n, done_at;
        cs_n = 0; rd_n = 0; ram_n = 0; done_at = 0;
        bus.nwrite_ar_mbx = 1'b0; bus.aext = 8'h80; bus.ibus = 16'h0010; tick();
        bus.nwrite_ar_mbx = 1'b1; tick();
        bus.nmem = 1'b0; bus.rnw = 1'b1; tick();
        bus.nmem = 1'b1;
        for (int k = 1; k <= ROM_WS_E + 4; k++) begin
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL rom_read_cyc%0d got %h exp %h", k, dut_vec(), exp_vec());
            end
            if (!bus.nromcs) cs_n++;
            if (!bus.nmemr)  rd_n++;
            if (!bus.nramcs) ram_n++;
            if (bus.done && done_at == 0) done_at = k;
            tick();
        end
        checks++;
        if (cs_n != ROM_WS_E + 3 || rd_n != ROM_WS_E + 1 || ram_n != 0 || done_at != ROM_WS_E + 3) begin
            errors++;
            $display("FAIL rom_read_timing got cs=%0d rd=%0d ram=%0d done@%0d exp cs=%0d rd=%0d ram=0 done@%0d",
                     cs_n, rd_n, ram_n, done_at, ROM_WS_E + 3, ROM_WS_E + 1, ROM_WS_E + 3);
        end
    endtask

    task automatic test_ram_write_rearm();
        int cs_n, wr_n, rom_n, dones;
        bit found;
        cs_n = 0; wr_n = 0; rom_n = 0; dones = 0; found = 1'b0;
        bus.nwrite_ar_mbx = 1'b0; bus.aext = 8'h00; bus.ibus = 16'h0020; tick();
        bus.nwrite_ar_mbx = 1'b1; tick();
        bus.nmem = 1'b0; bus.rnw = 1'b0;
        for (int i = 0; i < RAM_WS_E + 13; i++) begin
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL ram_write_cyc%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
            if (!bus.nramcs) cs_n++;
            if (!bus.nmemw)  wr_n++;
            if (!bus.nromcs) rom_n++;
            if (bus.done)    dones++;
        end
        checks++;
        if (cs_n != RAM_WS_E + 3 || wr_n != RAM_WS_E + 1 || rom_n != 0 || dones != 1) begin
            errors++;
            $display("FAIL ram_write_single got cs=%0d wr=%0d rom=%0d done=%0d exp cs=%0d wr=%0d rom=0 done=1",
                     cs_n, wr_n, rom_n, dones, RAM_WS_E + 3, RAM_WS_E + 1);
        end
        bus.nmem = 1'b1; tick();
        bus.nmem = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick();
            if (bus.done) found = 1'b1;
        end
        bus.nmem = 1'b1;
        checks++;
        if (!found) begin
            errors++; $display("FAIL rearm_new_cycle got done=0 exp done=1 within 10 cycles");
        end
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        bus.nwrite_ar_mbx = 1'b0; bus.aext = 8'h80; bus.ibus = 16'h0040; tick();
        bus.nwrite_ar_mbx = 1'b1; tick();
        bus.nmem = 1'b0; bus.rnw = 1'b1; tick();
        bus.nmem = 1'b1; tick();
        bus.nwrite_ar_mbx = 1'b0; bus.aext = 8'h00; bus.ibus = 16'hBEEF; tick();
        bus.nwrite_ar_mbx = 1'b1;
        checks++;
        if (bus.ab !== 24'h800040 || dut_vec() !== exp_vec()) begin
            errors++; $display("FAIL load_ignored_busy got %h exp %h", bus.ab, 24'h800040);
        end
        for (int i = 0; i < 8 && m_busy; i++) tick();
        bus.nmem = 1'b0; tick();
        bus.nmem = 1'b1; tick();
        rst = 1'b1; bus.nwrite_ar_mbx = 1'b0; bus.incar = 1'b1; bus.nmem = 1'b0; bus.aext = 8'h12;
        tick();
        checks++;
        if (dut_vec() !== RESET_VEC) begin
            errors++; $display("FAIL reset_mid_strobe got %h exp %h", dut_vec(), RESET_VEC);
        end
        rst = 1'b0; bus.nwrite_ar_mbx = 1'b1; bus.incar = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (dut_vec() !== exp_vec() || bus.nwaitm !== 1'b1) begin
            errors++; $display("FAIL reset_mid_disarm got %h exp %h", dut_vec(), exp_vec());
        end
        bus.nmem = 1'b1; tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 79) == 0);
            bus.nwrite_ar_mbx = ($urandom_range(0, 5) != 0);
            bus.incar = 1'($urandom_range(0, 1));
            bus.nmem  = ($urandom_range(0, 2) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            bus.rnw   = 1'($urandom_range(0, 1));
            bus.aext  = 8'($urandom);
            bus.ibus  = ($urandom_range(0, 3) == 0) ? 16'hFFFE : 16'($urandom);
            tick();
            checks++;
            if (dut_vec() !== exp_vec()) begin
                errors++; $display("FAIL random_cyc%0d got %h exp %h", i, dut_vec(), exp_vec());
            end
            checks++;
            if ((!bus.nromcs && !bus.nramcs) || (!bus.nmemr && !bus.nmemw) ||
                ((!bus.nmemr || !bus.nmemw) && bus.nromcs && bus.nramcs)) begin
                errors++;
                $display("FAIL random_exclusive_cyc%0d got cs=%b%b strb=%b%b exp no overlap",
                         i, bus.nromcs, bus.nramcs, bus.nmemr, bus.nmemw);
            end
        end
        rst = 1'b0; idle_inputs();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; errors = 0;
        m_ab = '0; m_busy = 1'b0; m_armed = 1'b0; m_rom = 1'b0; m_rd = 1'b0; m_k = 0; m_ws = 0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_load_inc();
        test_wrap();
        test_rom_read();
        test_ram_write_rearm();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
